// File: rtl/button_event.sv
// Button event generator: stability filter on an already-synchronised level, then press/release/auto-repeat strobes.
// All outputs registered; held and press/release follow the STABLE_CNT-th differing edge, first repeat DELAY_CNT cycles after press.
module button_event #(
    parameter int STABLE_CNT = 4,
    parameter int DELAY_CNT  = 25_000_000,
    parameter int RATE_CNT   = 5_000_000,
    parameter int CNT_W      = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_level,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Terminal counts: the event fires on the edge where the counter already holds N-1.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CNT - 1);
    localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(RATE_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             held_q, held_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             accept;

    always_comb begin
        filt_cnt_d = '0;
        rep_cnt_d  = rep_cnt_q;
        state_d    = state_q;
        held_d     = held_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;
        accept     = 1'b0;

        if (button_level != held_q) begin
            if (filt_cnt_q == STABLE_LAST) begin
                accept = 1'b1;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end

        // A release accepted on a repeat boundary takes priority over the repeat.
        case (state_q)
            IDLE: begin
                rep_cnt_d = '0;
                if (accept) begin
                    held_d  = 1'b1;
                    press_d = 1'b1;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (accept) begin
                    held_d    = 1'b0;
                    release_d = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = IDLE;
                end else if (rep_cnt_q == DELAY_LAST) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = REPEAT;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (accept) begin
                    held_d    = 1'b0;
                    release_d = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = IDLE;
                end else if (rep_cnt_q == RATE_LAST) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                held_d    = 1'b0;
                rep_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            filt_cnt_q <= '0;
            rep_cnt_q  <= '0;
            held_q     <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            filt_cnt_q <= filt_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            held_q     <= held_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
        end
    end

    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: two parameterisations share one stimulus; a timeline model predicts every output each cycle.
module tb_button_event;

    localparam int S0 = 4, D0 = 10, R0 = 3;
    localparam int S1 = 1, D1 = 2,  R1 = 1;
    localparam int PS [2] = '{S0, S1};
    localparam int PD [2] = '{D0, D1};
    localparam int PR [2] = '{R0, R1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       level = 1'b0;
    logic [1:0] held, prs, rel, rpt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_event #(.STABLE_CNT(S0), .DELAY_CNT(D0), .RATE_CNT(R0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .button_level(level), .held(held[0]),
        .press_pulse(prs[0]), .release_pulse(rel[0]), .repeat_pulse(rpt[0]));

    button_event #(.STABLE_CNT(S1), .DELAY_CNT(D1), .RATE_CNT(R1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .button_level(level), .held(held[1]),
        .press_pulse(prs[1]), .release_pulse(rel[1]), .repeat_pulse(rpt[1]));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Timeline model: held flips after PS consecutive differing edges; repeats at press edge + D + k*R.
    int m_run [2];
    int m_pedge [2];
    bit m_held [2];
    bit m_prs [2];
    bit m_rel [2];
    bit m_rpt [2];
    int ec;
    int n;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ec = 0;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_pedge[i] = 0; m_held[i] = 0;
                m_prs[i] = 0; m_rel[i] = 0; m_rpt[i] = 0;
            end
        end else begin
            ec++;
            for (int i = 0; i < 2; i++) begin
                m_prs[i] = 0;
                m_rel[i] = 0;
                if (level != m_held[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == PS[i]) begin
                    m_run[i]  = 0;
                    m_held[i] = !m_held[i];
                    if (m_held[i]) begin
                        m_prs[i]   = 1;
                        m_pedge[i] = ec;
                    end else begin
                        m_rel[i] = 1;
                    end
                end
                n = ec - m_pedge[i];
                m_rpt[i] = m_held[i] && !m_prs[i] && n >= PD[i] && ((n - PD[i]) % PR[i]) == 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("held%0d", i),    int'(held[i]), int'(m_held[i]));
            chk($sformatf("press%0d", i),   int'(prs[i]),  int'(m_prs[i]));
            chk($sformatf("release%0d", i), int'(rel[i]),  int'(m_rel[i]));
            chk($sformatf("repeat%0d", i),  int'(rpt[i]),  int'(m_rpt[i]));
            chk($sformatf("excl%0d", i), int'(({1'b0, prs[i]} + {1'b0, rel[i]} + {1'b0, rpt[i]}) <= 2'd1), 1);
        end
    end

    // Advance n rising edges, ending just after the following falling edge.
    task automatic step(input int n_edges);
        repeat (n_edges) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    int len;

    initial begin
        rst_n = 1'b0;
        level = 1'b0;
        step(2);
        chk("rst_held", int'(held[0]), 0);
        chk("rst_press", int'(prs[0]), 0);
        chk("rst_repeat", int'(rpt[0]), 0);
        rst_n = 1'b1;
        step(2);

        // glitch shorter than the filter
        level = 1'b1; step(3);
        level = 1'b0; step(6);
        chk("glitch_held", int'(held[0]), 0);

        // clean press and hold
        level = 1'b1; step(3);
        chk("press_early", int'(prs[0]), 0);
        step(1);
        chk("press_edge4", int'(prs[0]), 1);
        chk("held_edge4", int'(held[0]), 1);
        step(1);
        chk("press_width", int'(prs[0]), 0);
        step(8);
        chk("rep_pre", int'(rpt[0]), 0);
        step(1);
        chk("rep_p10", int'(rpt[0]), 1);
        step(1);
        chk("rep_width", int'(rpt[0]), 0);
        step(2);
        chk("rep_p13", int'(rpt[0]), 1);

        // release accepted exactly on the P+19 boundary
        step(2);
        level = 1'b0;
        step(1);
        chk("rep_p16", int'(rpt[0]), 1);
        step(3);
        chk("coin_release", int'(rel[0]), 1);
        chk("coin_repeat", int'(rpt[0]), 0);
        chk("coin_held", int'(held[0]), 0);

        // early release
        step(3);
        level = 1'b1; step(4);
        chk("press2", int'(prs[0]), 1);
        step(5);
        level = 1'b0; step(4);
        chk("early_release", int'(rel[0]), 1);
        chk("early_repeat", int'(rpt[0]), 0);

        // reset while in REPEAT, button kept down through reset
        step(3);
        level = 1'b1; step(4);
        chk("press3", int'(prs[0]), 1);
        step(12);
        rst_n = 1'b0;
        #1;
        chk("arst_held", int'(held[0]), 0);
        chk("arst_press", int'(prs[0]), 0);
        chk("arst_release", int'(rel[0]), 0);
        chk("arst_repeat", int'(rpt[0]), 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("rs_press_early", int'(prs[0]), 0);
        step(1);
        chk("rs_press", int'(prs[0]), 1);
        step(9);
        chk("rs_rep_pre", int'(rpt[0]), 0);
        step(1);
        chk("rs_rep", int'(rpt[0]), 1);

        // randomized segments with occasional resets
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
            level = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45)) : int'($urandom_range(1, 6));
            step(len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
